crc_packet_gen: RTL

Transmit-side counterpart of the SRAMC ingress CRC checker. Accepts payload bytes on a valid/ready stream and frames them as a wr_sop / wr_valid / wr_eop packet. Computes CRC-8 over the payload and appends it as the final valid data word, in the exact framing the checker expects. Sits in front of the SRAMC write port (or in the testbench traffic generator) and drives its wr_* inputs.

---
 rtl/crc_packet_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/crc_packet_gen.sv
// Frames a valid/ready payload stream into a wr_sop/wr_valid/wr_eop packet and
// appends a CRC-8 (MSB-first, unreflected) as the final data word.
`timescale 1ns/1ps

module crc_packet_gen #(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          CRC_WIDTH   = 8,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL  = 8'h07,
  parameter logic [CRC_WIDTH-1:0] INIT_VALUE  = 8'h00,
  parameter int unsigned          MAX_PAYLOAD = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  crc_corrupt,
  output logic                  wr_sop,
  output logic                  wr_valid,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_eop,
  output logic                  busy,
  output logic                  len_err
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CRC_OUT,
    EOP,
    GAP
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(MAX_PAYLOAD - 1);

  state_t                state, state_next;
  logic [CRC_WIDTH-1:0]  crc, crc_nxt;
  logic [7:0]            count, count_nxt;
  logic                  trunc, trunc_nxt;
  logic                  sop_nxt, valid_nxt, eop_nxt, len_err_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [CRC_WIDTH-1:0]  corrupt_mask;

  // Bit-serial CRC over one word, most significant data bit first.
  function automatic logic [CRC_WIDTH-1:0] crc_update(
    input logic [CRC_WIDTH-1:0]  crc_in,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [CRC_WIDTH-1:0] c;
    c = crc_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (c[CRC_WIDTH-1] ^ d[i]) begin
        c = (c << 1) ^ POLYNOMIAL;
      end else begin
        c = c << 1;
      end
    end
    return c;
  endfunction

  assign in_ready     = (state == DATA);
  assign busy         = (state != IDLE);
  assign corrupt_mask = {{(CRC_WIDTH-1){1'b0}}, crc_corrupt};

  always_comb begin
    state_next  = state;
    sop_nxt     = 1'b0;
    valid_nxt   = 1'b0;
    eop_nxt     = 1'b0;
    len_err_nxt = 1'b0;
    data_nxt    = wr_data;
    crc_nxt     = crc;
    count_nxt   = count;
    trunc_nxt   = trunc;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sop_nxt    = 1'b1;
          crc_nxt    = INIT_VALUE;
          count_nxt  = '0;
          trunc_nxt  = 1'b0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (in_valid && in_ready) begin
          valid_nxt = 1'b1;
          data_nxt  = in_data;
          crc_nxt   = crc_update(crc, in_data);
          count_nxt = count + 8'd1;
          if (in_last) begin
            state_next = CRC_OUT;
          end else if (count == LAST_IDX) begin
            // Payload hit the length cap: close this packet, flag it at eop.
            state_next = CRC_OUT;
            trunc_nxt  = 1'b1;
          end
        end
      end
      CRC_OUT: begin
        valid_nxt  = 1'b1;
        data_nxt   = crc ^ corrupt_mask;
        state_next = EOP;
      end
      EOP: begin
        eop_nxt     = 1'b1;
        len_err_nxt = trunc;
        trunc_nxt   = 1'b0;
        state_next  = GAP;
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_sop   <= 1'b0;
      wr_valid <= 1'b0;
      wr_eop   <= 1'b0;
      len_err  <= 1'b0;
      wr_data  <= '0;
      crc      <= INIT_VALUE;
      count    <= '0;
      trunc    <= 1'b0;
    end else begin
      state    <= state_next;
      wr_sop   <= sop_nxt;
      wr_valid <= valid_nxt;
      wr_eop   <= eop_nxt;
      len_err  <= len_err_nxt;
      wr_data  <= data_nxt;
      crc      <= crc_nxt;
      count    <= count_nxt;
      trunc    <= trunc_nxt;
    end
  end

endmodule
